// File: rtl/salsa_pkg.sv
// Shared Salsa20 constants, word types, quarterround tuple tables and rotate helper.
package salsa_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned NWORDS  = 16;
  localparam int unsigned STATE_W = WORD_W * NWORDS;
  localparam int unsigned QR_N    = 4;
  localparam int unsigned QR_W    = 4;
  localparam int unsigned IDX_W   = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  widx_t;

  // Quarterround operands; a is the word that gets updated last.
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
  } qr_tuple_t;

  typedef enum logic {
    ROUND_ROW = 1'b0,
    ROUND_COL = 1'b1
  } round_e;

  // Diagonal constants loaded into words 0/5/10/15 by the hash core.
  localparam word_t SIGMA0 = 32'h6170_7865;
  localparam word_t SIGMA1 = 32'h3320_646e;
  localparam word_t SIGMA2 = 32'h7962_2d32;
  localparam word_t SIGMA3 = 32'h6b20_6574;

  // Word indices (a,b,c,d) for each of the four quarterrounds.
  localparam widx_t COL_IDX [QR_N][QR_W] = '{
    '{4'd0,  4'd4,  4'd8,  4'd12},
    '{4'd5,  4'd9,  4'd13, 4'd1 },
    '{4'd10, 4'd14, 4'd2,  4'd6 },
    '{4'd15, 4'd3,  4'd7,  4'd11}
  };

  localparam widx_t ROW_IDX [QR_N][QR_W] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3 },
    '{4'd5,  4'd6,  4'd7,  4'd4 },
    '{4'd10, 4'd11, 4'd8,  4'd9 },
    '{4'd15, 4'd12, 4'd13, 4'd14}
  };

  // 32-bit rotate-left by a constant amount (1..31).
  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

  // Sigma word lookup for the core's state assembly.
  function automatic word_t sigma_word(input logic [1:0] sel);
    word_t w;
    case (sel)
      2'd0:    w = SIGMA0;
      2'd1:    w = SIGMA1;
      2'd2:    w = SIGMA2;
      default: w = SIGMA3;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/salsa_quarter_round.sv
// Combinational Salsa20 quarterround on one (a,b,c,d) tuple.
module salsa_quarter_round
  import salsa_pkg::*;
(
  input  qr_tuple_t tuple_in,
  output qr_tuple_t tuple_out_c
);

  word_t a_c;
  word_t b_c;
  word_t c_c;
  word_t d_c;

  // Four dependent add-rotate-xor steps; each uses the word just updated.
  always_comb begin
    b_c = tuple_in.b ^ rotl(word_t'(tuple_in.a + tuple_in.d), 7);
    c_c = tuple_in.c ^ rotl(word_t'(b_c + tuple_in.a), 9);
    d_c = tuple_in.d ^ rotl(word_t'(c_c + b_c), 13);
    a_c = tuple_in.a ^ rotl(word_t'(d_c + c_c), 18);
    tuple_out_c = '{a: a_c, b: b_c, c: c_c, d: d_c};
  end

endmodule

// File: rtl/salsa_round_unit.sv
// One registered Salsa20 column or row round over the 16-word state.
module salsa_round_unit
  import salsa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               round_sel,
  input  logic [STATE_W-1:0] data_in,
  output logic               out_valid,
  output logic [STATE_W-1:0] data_out
);

  word_t        in_words   [NWORDS];
  word_t        res_words  [NWORDS];
  widx_t        sel_idx    [QR_N][QR_W];
  qr_tuple_t    qr_in      [QR_N];
  qr_tuple_t    qr_out     [QR_N];
  round_e       round_kind_c;
  logic [STATE_W-1:0] round_result_c;

  logic               out_valid_q, out_valid_d;
  logic [STATE_W-1:0] data_out_q,  data_out_d;

  assign round_kind_c = round_e'(round_sel);

  // Unpack the state and pick the tuple mapping for this round type.
  always_comb begin
    for (int unsigned i = 0; i < NWORDS; i++) begin
      in_words[i] = data_in[WORD_W*i +: WORD_W];
    end
    for (int unsigned q = 0; q < QR_N; q++) begin
      for (int unsigned k = 0; k < QR_W; k++) begin
        sel_idx[q][k] = (round_kind_c == ROUND_COL) ? COL_IDX[q][k] : ROW_IDX[q][k];
      end
    end
  end

  // Gather each quarterround's operands from the selected word positions.
  always_comb begin
    for (int unsigned q = 0; q < QR_N; q++) begin
      qr_in[q] = '{a: in_words[sel_idx[q][0]],
                   b: in_words[sel_idx[q][1]],
                   c: in_words[sel_idx[q][2]],
                   d: in_words[sel_idx[q][3]]};
    end
  end

  for (genvar g = 0; g < QR_N; g++) begin : g_qr
    salsa_quarter_round u_qr (
      .tuple_in    (qr_in[g]),
      .tuple_out_c (qr_out[g])
    );
  end

  // Scatter results back; the tables cover every word exactly once.
  always_comb begin
    for (int unsigned i = 0; i < NWORDS; i++) begin
      res_words[i] = '0;
    end
    for (int unsigned q = 0; q < QR_N; q++) begin
      res_words[sel_idx[q][0]] = qr_out[q].a;
      res_words[sel_idx[q][1]] = qr_out[q].b;
      res_words[sel_idx[q][2]] = qr_out[q].c;
      res_words[sel_idx[q][3]] = qr_out[q].d;
    end
    round_result_c = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      round_result_c[WORD_W*i +: WORD_W] = res_words[i];
    end
  end

  // Next output: capture a new result on in_valid, otherwise hold the data.
  always_comb begin
    out_valid_d = in_valid;
    data_out_d  = data_out_q;
    if (in_valid) begin
      data_out_d = round_result_c;
    end
  end

  // Output register with synchronous reset taking priority over in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_salsa_round_unit.sv
// Scoreboard bench for salsa_round_unit: driver queues expectations, monitor compares.
module tb_salsa_round_unit;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         round_sel;
  logic [511:0] data_in;
  logic         out_valid;
  logic [511:0] data_out;

  typedef struct {
    logic         v;
    logic [511:0] d;
    string        name;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [511:0] last_out = '0;
  logic [511:0] st;

  salsa_round_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .round_sel (round_sel),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference round written out in the style of the Salsa20 reference code.
  function automatic logic [511:0] ref_round(input logic [511:0] s, input logic col);
    logic [31:0] x [16];
    logic [511:0] o;
    for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
    if (col) begin
      x[4]  ^= r(x[0]+x[12],7);  x[8]  ^= r(x[4]+x[0],9);
      x[12] ^= r(x[8]+x[4],13);  x[0]  ^= r(x[12]+x[8],18);
      x[9]  ^= r(x[5]+x[1],7);   x[13] ^= r(x[9]+x[5],9);
      x[1]  ^= r(x[13]+x[9],13); x[5]  ^= r(x[1]+x[13],18);
      x[14] ^= r(x[10]+x[6],7);  x[2]  ^= r(x[14]+x[10],9);
      x[6]  ^= r(x[2]+x[14],13); x[10] ^= r(x[6]+x[2],18);
      x[3]  ^= r(x[15]+x[11],7); x[7]  ^= r(x[3]+x[15],9);
      x[11] ^= r(x[7]+x[3],13);  x[15] ^= r(x[11]+x[7],18);
    end else begin
      x[1]  ^= r(x[0]+x[3],7);   x[2]  ^= r(x[1]+x[0],9);
      x[3]  ^= r(x[2]+x[1],13);  x[0]  ^= r(x[3]+x[2],18);
      x[6]  ^= r(x[5]+x[4],7);   x[7]  ^= r(x[6]+x[5],9);
      x[4]  ^= r(x[7]+x[6],13);  x[5]  ^= r(x[4]+x[7],18);
      x[11] ^= r(x[10]+x[9],7);  x[8]  ^= r(x[11]+x[10],9);
      x[9]  ^= r(x[8]+x[11],13); x[10] ^= r(x[9]+x[8],18);
      x[12] ^= r(x[15]+x[14],7); x[13] ^= r(x[12]+x[15],9);
      x[14] ^= r(x[13]+x[12],13); x[15] ^= r(x[14]+x[13],18);
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i];
    return o;
  endfunction

  function automatic logic [511:0] rand_state();
    logic [511:0] s;
    for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  function automatic void push(input logic v, input logic [511:0] d, input string name);
    exp_t e;
    e.v = v; e.d = d; e.name = name;
    exp_q.push_back(e);
  endfunction

  // Drive one cycle; expectation comes from the reference model.
  task automatic drive(input logic rst, input logic v, input logic sel,
                       input logic [511:0] d, input string name);
    @(negedge clk);
    reset = rst; in_valid = v; round_sel = sel; data_in = d;
    if (rst)    last_out = '0;
    else if (v) last_out = ref_round(d, sel);
    push(!rst && v, last_out, name);
  endtask

  // Drive one valid cycle with a hand-computed expected result.
  task automatic drive_const(input logic sel, input logic [511:0] d,
                             input logic [511:0] exp_d, input string name);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b1; round_sel = sel; data_in = d;
    last_out = exp_d;
    push(1'b1, exp_d, name);
  endtask

  // Monitor: one result per cycle, sampled 1 time unit after the rising edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (out_valid !== e.v || data_out !== e.d)
        $display("FAIL %s: out_valid=%b data_out=%h required out_valid=%b data_out=%h",
                 e.name, out_valid, data_out, e.v, e.d);
      else
        n_pass++;
    end
  end

  initial begin
    logic [511:0] one_col;
    logic [511:0] col_exp;
    logic [511:0] row_exp;
    logic [31:0]  row_w [16];
    int           wait_cyc;

    reset = 1'b1; in_valid = 1'b0; round_sel = 1'b0; data_in = '0;

    one_col = '0;
    one_col[32*0 +: 32] = 32'h1; one_col[32*4 +: 32] = 32'h1;
    one_col[32*8 +: 32] = 32'h1; one_col[32*12 +: 32] = 32'h1;
    col_exp = '0;
    col_exp[32*0 +: 32]  = 32'h10090288; col_exp[32*4 +: 32]  = 32'h00000101;
    col_exp[32*8 +: 32]  = 32'h00020401; col_exp[32*12 +: 32] = 32'h40a04001;
    row_w = '{32'h08008145, 32'h00000080, 32'h00010200, 32'h20500000,
              32'h20100001, 32'h00048044, 32'h00000080, 32'h00010000,
              32'h00000001, 32'h00002000, 32'h80040000, 32'h00000000,
              32'h00000001, 32'h00000200, 32'h00402000, 32'h88000100};
    for (int i = 0; i < 16; i++) row_exp[32*i +: 32] = row_w[i];

    drive(1'b1, 1'b0, 1'b0, '0, "reset_idle");
    drive(1'b1, 1'b0, 1'b0, '0, "reset_idle2");
    drive(1'b1, 1'b1, 1'b1, rand_state(), "reset_wins");

    drive_const(1'b1, '0, '0, "zero_col");
    drive_const(1'b0, '0, '0, "zero_row");
    drive_const(1'b1, one_col, col_exp, "col_vector");
    drive_const(1'b0, one_col, row_exp, "row_vector");
    drive(1'b0, 1'b0, 1'b0, rand_state(), "hold_after_row");
    drive(1'b0, 1'b0, 1'b1, rand_state(), "hold_again");

    st = rand_state();
    drive(1'b0, 1'b1, 1'b1, st, "b2b_col");
    drive(1'b0, 1'b1, 1'b0, st, "b2b_row");
    drive(1'b0, 1'b0, 1'b1, '0, "gap_hold");
    drive(1'b0, 1'b1, 1'b1, rand_state(), "after_gap");
    drive(1'b1, 1'b0, 1'b0, '0, "mid_reset");
    drive(1'b0, 1'b0, 1'b0, rand_state(), "idle_after_reset");

    // Twenty alternating rounds, column first, fed back-to-back.
    st = rand_state();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, (k % 2 == 0), st, "chain_round");
      st = ref_round(st, (k % 2 == 0));
    end
    drive_const(1'b1, {16{32'h0}}, '0, "chain_zero_tail");

    for (int k = 0; k < 1000; k++) begin
      drive(1'b0, ($urandom_range(0, 7) != 0), $urandom_range(0, 1), rand_state(), "random");
    end
    drive(1'b0, 1'b0, 1'b0, '0, "final_idle");

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
